// File: rtl/spi_flash_resp_pkg.sv
// Shared opcodes and FSM encoding for the SPI flash responder.
// SPI_FLASH_RESP_RDID_EN adds the RDID (9Fh) state; without it 9Fh is an unknown opcode.
package spi_flash_resp_pkg;

  localparam logic [7:0] OpNone = 8'h00;  // no honoured command
  localparam logic [7:0] OpRead = 8'h03;
  localparam logic [7:0] OpPp   = 8'h02;
  localparam logic [7:0] OpSe   = 8'h20;
  localparam logic [7:0] OpRdsr = 8'h05;
  localparam logic [7:0] OpRdid = 8'h9F;
  localparam logic [7:0] OpWren = 8'h06;
  localparam logic [7:0] OpWrdi = 8'h04;

  localparam int unsigned SectorAw = 12;  // 4 KB erase sector

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StAddr,
    StRdData,
    StPpData,
    StStatus,
`ifdef SPI_FLASH_RESP_RDID_EN
    StId,
`endif
    StIgnore
  } state_e;

  // States in which the responder drives miso
  function automatic logic is_out_state(input state_e s);
`ifdef SPI_FLASH_RESP_RDID_EN
    return (s == StRdData) || (s == StStatus) || (s == StId);
`else
    return (s == StRdData) || (s == StStatus);
`endif
  endfunction

endpackage

// File: rtl/spi_resp_sync.sv
// Two-flop synchronisers for the SPI pins plus dclk/ncs edge detection in the clk domain.
module spi_resp_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ncs,
  input  logic dclk,
  input  logic mosi,
  output logic mosi_s,
  output logic dclk_rise,
  output logic dclk_fall,
  output logic ncs_rise,
  output logic ncs_fall
);

  logic [1:0] ncs_sync, dclk_sync, mosi_sync;
  logic       ncs_prev, dclk_prev;

  // Synchroniser chains plus one history flop for edge detection; idle is ncs=1, dclk=0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncs_sync  <= 2'b11;
      dclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      ncs_prev  <= 1'b1;
      dclk_prev <= 1'b0;
    end else begin
      ncs_sync  <= {ncs_sync[0], ncs};
      dclk_sync <= {dclk_sync[0], dclk};
      mosi_sync <= {mosi_sync[0], mosi};
      ncs_prev  <= ncs_sync[1];
      dclk_prev <= dclk_sync[1];
    end
  end

  assign mosi_s    = mosi_sync[1];
  assign dclk_rise = dclk_sync[1] & ~dclk_prev;
  assign dclk_fall = ~dclk_sync[1] & dclk_prev;
  assign ncs_rise  = ncs_sync[1] & ~ncs_prev;
  assign ncs_fall  = ~ncs_sync[1] & ncs_prev;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: READ, PP, SE, RDSR, WREN/WRDI and optional RDID.
// Define SPI_FLASH_RESP_RDID_EN to enable the RDID (9Fh) JEDEC ID response.
module spi_flash_responder #(
  parameter int unsigned ADDR_W      = 14,
  parameter logic [23:0] JEDEC_ID    = 24'hEF4015,
  parameter int unsigned BUSY_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ncs,
  input  logic dclk,
  input  logic mosi,
  output logic miso,
  output logic miso_oe,
  output logic busy
);
  import spi_flash_resp_pkg::*;

  localparam int unsigned BusyW = (BUSY_CYCLES > 0) ? $clog2(BUSY_CYCLES + 1) : 1;

  if (ADDR_W < SectorAw || ADDR_W > 24) begin : g_bad_addr_w
    $error("ADDR_W must be in 12..24");
  end
  if (JEDEC_ID[23:16] == 8'h00) begin : g_bad_jedec
    $error("JEDEC_ID needs a non-zero manufacturer code");
  end

  logic mosi_s, dclk_rise, dclk_fall, ncs_rise, ncs_fall;

  spi_resp_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .ncs       (ncs),
    .dclk      (dclk),
    .mosi      (mosi),
    .mosi_s    (mosi_s),
    .dclk_rise (dclk_rise),
    .dclk_fall (dclk_fall),
    .ncs_rise  (ncs_rise),
    .ncs_fall  (ncs_fall)
  );

  state_e                   state_q;
  logic [2:0]               bit_cnt_q, byte_cnt_q;
  logic [6:0]               sr_q, out_sr_q;
  logic [7:0]               cmd_q;
  logic [ADDR_W-1:0]        addr_q;
  logic                     load_q, pp_wr_q, wel_q, wip_q, erase_q;
  logic [BusyW-1:0]         busy_cnt_q;
  logic [SectorAw-1:0]      erase_cnt_q;
  logic [ADDR_W-SectorAw-1:0] sector_q;
`ifdef SPI_FLASH_RESP_RDID_EN
  logic [1:0]               id_idx_q;
`endif

  // Memory is stored inverted so the zero power-up state of the array reads as erased FFh
  logic [7:0]        mem_inv [2**ADDR_W];
  logic [7:0]        rdata_q, ram_wdata, byte_val, out_byte;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we, byte_done, pp_we, aligned;

  assign byte_val  = {sr_q, mosi_s};
  assign byte_done = dclk_rise && !ncs_rise && !ncs_fall && (state_q != StIdle) &&
                     (bit_cnt_q == 3'd7);
  assign pp_we     = (state_q == StPpData) && byte_done && wel_q && !wip_q;
  assign aligned   = (bit_cnt_q == 3'd0);
  assign busy      = wip_q;

  // Single RAM port: erase sweep owns it, else a PP read-modify-write, else reads at addr_q
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = 8'hFF;
    if (erase_q) begin
      ram_we   = 1'b1;
      ram_addr = {sector_q, erase_cnt_q};
    end else if (pp_we) begin
      ram_we    = 1'b1;
      ram_wdata = rdata_q & byte_val;
    end
  end

  // Single-port synchronous RAM, deliberately not reset
  always_ff @(posedge clk) begin
    if (ram_we) mem_inv[ram_addr] <= ~ram_wdata;
    else        rdata_q <= ~mem_inv[ram_addr];
  end

  // Byte presented at the start of each output byte
  always_comb begin
    out_byte = 8'h00;
    case (state_q)
      StRdData: out_byte = rdata_q;
      StStatus: out_byte = {6'b0, wel_q, wip_q};
`ifdef SPI_FLASH_RESP_RDID_EN
      StId: begin
        case (id_idx_q)
          2'd0:    out_byte = JEDEC_ID[23:16];
          2'd1:    out_byte = JEDEC_ID[15:8];
          2'd2:    out_byte = JEDEC_ID[7:0];
          default: out_byte = 8'h00;
        endcase
      end
`endif
      default: out_byte = 8'h00;
    endcase
  end

  // Protocol FSM, status bits, busy timer and erase sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      sr_q        <= '0;
      out_sr_q    <= '0;
      cmd_q       <= OpNone;
      addr_q      <= '0;
      load_q      <= 1'b0;
      pp_wr_q     <= 1'b0;
      wel_q       <= 1'b0;
      wip_q       <= 1'b0;
      erase_q     <= 1'b0;
      busy_cnt_q  <= '0;
      erase_cnt_q <= '0;
      sector_q    <= '0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
`ifdef SPI_FLASH_RESP_RDID_EN
      id_idx_q    <= '0;
`endif
    end else begin
      if (busy_cnt_q != '0) busy_cnt_q <= busy_cnt_q - 1'b1;
      if (erase_q) begin
        erase_cnt_q <= erase_cnt_q + 1'b1;
        if (&erase_cnt_q) erase_q <= 1'b0;
      end
      if (wip_q && (busy_cnt_q == '0) && !erase_q) wip_q <= 1'b0;

      if (ncs_rise) begin
        state_q <= StIdle;
        load_q  <= 1'b0;
        miso    <= 1'b0;
        miso_oe <= 1'b0;
        // Completed PP bytes commit even when the transfer ends mid-byte
        if ((cmd_q == OpPp) && pp_wr_q) begin
          wip_q      <= 1'b1;
          wel_q      <= 1'b0;
          busy_cnt_q <= BusyW'(BUSY_CYCLES);
        end
        if (aligned && (byte_cnt_q == 3'd1)) begin
          if (cmd_q == OpWren) wel_q <= 1'b1;
          if (cmd_q == OpWrdi) wel_q <= 1'b0;
        end
        if ((cmd_q == OpSe) && aligned && (byte_cnt_q == 3'd4) && wel_q && !wip_q) begin
          erase_q     <= 1'b1;
          erase_cnt_q <= '0;
          sector_q    <= addr_q[ADDR_W-1:SectorAw];
          wip_q       <= 1'b1;
          wel_q       <= 1'b0;
          busy_cnt_q  <= BusyW'(BUSY_CYCLES);
        end
      end else if (ncs_fall) begin
        state_q    <= StCmd;
        bit_cnt_q  <= '0;
        byte_cnt_q <= '0;
        cmd_q      <= OpNone;
        pp_wr_q    <= 1'b0;
        load_q     <= 1'b0;
      end else if (state_q != StIdle) begin
        if (dclk_rise) begin
          sr_q      <= {sr_q[5:0], mosi_s};
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
        if (byte_done) begin
          if (byte_cnt_q != 3'd7) byte_cnt_q <= byte_cnt_q + 1'b1;
          case (state_q)
            StCmd: begin
              if (wip_q && (byte_val != OpRdsr)) begin
                cmd_q   <= OpNone;
                state_q <= StIgnore;
              end else begin
                cmd_q <= byte_val;
                case (byte_val)
                  OpRead, OpPp, OpSe: state_q <= StAddr;
                  OpRdsr: begin
                    state_q <= StStatus;
                    load_q  <= 1'b1;
                  end
`ifdef SPI_FLASH_RESP_RDID_EN
                  OpRdid: begin
                    state_q  <= StId;
                    load_q   <= 1'b1;
                    id_idx_q <= '0;
                  end
`endif
                  default: state_q <= StIgnore;
                endcase
              end
            end
            StAddr: begin
              // Shifting all 24 bits keeps only the low ADDR_W of them
              addr_q <= ADDR_W'({addr_q, byte_val});
              if (byte_cnt_q == 3'd3) begin
                case (cmd_q)
                  OpRead: begin
                    state_q <= StRdData;
                    load_q  <= 1'b1;
                  end
                  OpPp:    state_q <= StPpData;
                  default: state_q <= StIgnore;
                endcase
              end
            end
            StPpData: begin
              if (pp_we) begin
                addr_q[7:0] <= addr_q[7:0] + 8'd1;
                pp_wr_q     <= 1'b1;
              end
            end
            default: load_q <= is_out_state(state_q);
          endcase
        end
        if (dclk_fall && is_out_state(state_q)) begin
          if (load_q) begin
            miso     <= out_byte[7];
            out_sr_q <= out_byte[6:0];
            miso_oe  <= 1'b1;
            load_q   <= 1'b0;
            if (state_q == StRdData) addr_q <= addr_q + 1'b1;
`ifdef SPI_FLASH_RESP_RDID_EN
            if ((state_q == StId) && (id_idx_q != 2'd3)) id_idx_q <= id_idx_q + 1'b1;
`endif
          end else begin
            miso     <= out_sr_q[6];
            out_sr_q <= {out_sr_q[5:0], 1'b0};
          end
        end
      end
    end
  end

endmodule
